// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: sizes, instruction
// field positions and the controller state encoding.
package alu_pkg;

    localparam int NUM_REGS = 8;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int OP_W     = 5;
    localparam int INSTR_W  = 16;
    localparam int CNT_W    = 3;

    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 11;
    localparam int RD_MSB    = 10;
    localparam int RD_LSB    = 8;
    localparam int RA_MSB    = 7;
    localparam int RA_LSB    = 5;
    localparam int WB_EN_BIT = 4;
    localparam int RSV_MSB   = 3;
    localparam int RSV_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

endpackage

// File: rtl/alu_regfile.sv
// 8 x 8 register file: one synchronous write port, two asynchronous read ports.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Storage: reset clears every entry, otherwise single-port write
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (i_we) begin
            regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = regs[i_raddr_a];
    assign o_rdata_b = regs[i_raddr_b];

endmodule

// File: rtl/alu_issue.sv
// Single-issue controller in front of an external fixed-latency ALU.
// Accepts one instruction at a time, presents registered operands, waits
// ALU_LAT cycles for the result, then writes it back and updates flags.
//
// state | meaning
// IDLE  | ready for a load or a new instruction
// ISSUE | o_en_alu strobe with latched operands
// WAIT  | counting ALU latency, result captured on the last WAIT cycle
// WB    | writeback pulse, flags committed
module alu_issue
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_instr_valid,
    output logic               o_instr_ready,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_ld_valid,
    input  logic [ADDR_W-1:0]  i_ld_addr,
    input  logic [DATA_W-1:0]  i_ld_data,
    output logic               o_en_alu,
    output logic [DATA_W-1:0]  o_RD,
    output logic [DATA_W-1:0]  o_RA,
    output logic [OP_W-1:0]    o_aluop,
    input  logic [DATA_W-1:0]  i_alu_out,
    input  logic               i_alu_cy,
    input  logic               i_alu_zy,
    output logic               o_wb_valid,
    output logic [ADDR_W-1:0]  o_wb_addr,
    output logic [DATA_W-1:0]  o_wb_data,
    output logic               o_flag_cy,
    output logic               o_flag_zy,
    output logic               o_busy
);

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(ALU_LAT - 1);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   rd_q;
    logic                wb_en_q;
    logic [DATA_W-1:0]   res_q;
    logic                res_cy_q, res_zy_q;

    logic [ADDR_W-1:0]   rd_idx, ra_idx;
    logic [DATA_W-1:0]   rd_val, ra_val;
    logic                accept, ld_fire, wb_fire, res_take;
    logic                rf_we;
    logic [ADDR_W-1:0]   rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;

    // Reserved instruction bits are deliberately ignored
    logic unused_rsvd;
    assign unused_rsvd = ^i_instr[RSV_MSB:RSV_LSB];

    assign rd_idx = i_instr[RD_MSB:RD_LSB];
    assign ra_idx = i_instr[RA_MSB:RA_LSB];

    // Loads win over instructions, and only ever land while idle
    assign o_instr_ready = (state == ST_IDLE) && !i_ld_valid;
    assign accept        = i_instr_valid && o_instr_ready;
    assign ld_fire       = (state == ST_IDLE) && i_ld_valid;
    assign wb_fire       = (state == ST_WB) && wb_en_q;
    assign res_take      = (state == ST_WAIT) && (cnt == LAT_LAST);

    // Load and writeback never coincide, so one write port suffices
    assign rf_we    = ld_fire || wb_fire;
    assign rf_waddr = (state == ST_WB) ? rd_q  : i_ld_addr;
    assign rf_wdata = (state == ST_WB) ? res_q : i_ld_data;

    alu_regfile u_regfile (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_we      (rf_we),
        .i_waddr   (rf_waddr),
        .i_wdata   (rf_wdata),
        .i_raddr_a (rd_idx),
        .o_rdata_a (rd_val),
        .i_raddr_b (ra_idx),
        .o_rdata_b (ra_val)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (cnt == LAT_LAST) state_nxt = ST_WB;
            ST_WB:    state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Latch operands and instruction fields at accept; they hold until the next accept
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_RD    <= '0;
            o_RA    <= '0;
            o_aluop <= '0;
            rd_q    <= '0;
            wb_en_q <= 1'b0;
        end else if (accept) begin
            o_RD    <= rd_val;
            o_RA    <= ra_val;
            o_aluop <= i_instr[OP_MSB:OP_LSB];
            rd_q    <= rd_idx;
            wb_en_q <= i_instr[WB_EN_BIT];
        end
    end

    // Latency counter: cleared on the way into WAIT, advances each WAIT cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (state == ST_ISSUE) begin
            cnt <= '0;
        end else if (state == ST_WAIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Capture ALU result and flags on the cycle they are valid
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            res_q    <= '0;
            res_cy_q <= 1'b0;
            res_zy_q <= 1'b0;
        end else if (res_take) begin
            res_q    <= i_alu_out;
            res_cy_q <= i_alu_cy;
            res_zy_q <= i_alu_zy;
        end
    end

    // Architectural flags commit in WB whether or not the register is written
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_flag_cy <= 1'b0;
            o_flag_zy <= 1'b0;
        end else if (state == ST_WB) begin
            o_flag_cy <= res_cy_q;
            o_flag_zy <= res_zy_q;
        end
    end

    assign o_en_alu   = (state == ST_ISSUE);
    assign o_wb_valid = wb_fire;
    assign o_wb_addr  = rd_q;
    assign o_wb_data  = res_q;
    assign o_busy     = (state != ST_IDLE);

endmodule
